// File: rtl/fifo_traffic_generator.sv
// Stimulus/checker for an external FIFO: fill to full, drain, an LFSR-driven random mix,
// then flush. Pushes a running counter and checks popped data against the same sequence.
module fifo_traffic_generator #(
  parameter int          width                         = 8,
  parameter int          depth                         = 4,
  parameter bit          allow_push_when_full_with_pop = 1'b0,
  parameter int          random_cycles                 = 64,
  parameter logic [15:0] lfsr_seed                     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             empty,
  input  logic             full,
  input  logic [width-1:0] read_data,
  output logic             push,
  output logic             pop,
  output logic [width-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [7:0]       err_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FILL   = 3'd1;
  localparam logic [2:0] DRAIN  = 3'd2;
  localparam logic [2:0] RANDOM = 3'd3;
  localparam logic [2:0] FLUSH  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam logic [31:0] last_cycle = 32'(random_cycles - 1);

  // The generator is meaningless with an empty FIFO, no random phase or a locked-up LFSR.
  if (depth < 1 || random_cycles < 1 || lfsr_seed == 16'h0000) begin : g_param_check
    $error("fifo_traffic_generator: invalid parameter set");
  end

  logic [2:0]       state;
  logic [width-1:0] wr_cnt;
  logic [width-1:0] exp_cnt;
  logic [31:0]      cyc_cnt;
  logic [15:0]      lfsr;
  logic             lfsr_fb;

  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign write_data = wr_cnt;
  assign busy       = (state == FILL) || (state == DRAIN) || (state == RANDOM) || (state == FLUSH);
  assign done       = (state == DONE);

  // Strobes are gated by rst so nothing leaks out while reset waits for its edge.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    push = 1'b0;
    pop  = 1'b0;
    if (!rst) begin
      case (state)
        FILL:         push = ~full;
        DRAIN, FLUSH: pop  = ~empty;
        RANDOM: begin
          pop  = lfsr[1] & ~empty;
          push = lfsr[0] & (~full | (allow_push_when_full_with_pop & pop));
        end
        default: ;
      endcase
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      exp_cnt   <= '0;
      err_count <= '0;
      error     <= 1'b0;
      cyc_cnt   <= '0;
      lfsr      <= lfsr_seed;
    end else begin
      error <= 1'b0;
      if (push) wr_cnt <= wr_cnt + 1'b1;
      if (pop) begin
        exp_cnt <= exp_cnt + 1'b1;
        if (read_data != exp_cnt) begin
          error <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end
      if (state == RANDOM) lfsr <= {lfsr[14:0], lfsr_fb};

      case (state)
        IDLE:  if (start) state <= FILL;
        FILL:  if (full) state <= DRAIN;
        DRAIN: begin
          if (empty) begin
            state   <= RANDOM;
            cyc_cnt <= '0;
          end
        end
        RANDOM: begin
          cyc_cnt <= cyc_cnt + 32'd1;
          if (cyc_cnt == last_cycle) state <= FLUSH;
        end
        FLUSH: if (empty) state <= DONE;
        DONE:  if (start) state <= FILL;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_traffic_generator.sv
// Bench for fifo_traffic_generator: an ideal/faulty FIFO environment plus a counter-based
// reference model of the data stream; scenario tasks predict phase behaviour from the rules.
module tb_fifo_traffic_generator;

  localparam int          W    = 8;
  localparam int          D    = 4;
  localparam int          RC   = 64;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         empty, full;
  logic [W-1:0] read_data;
  logic         push, pop, busy, done, error;
  logic [W-1:0] write_data;
  logic [7:0]   err_count;
  logic         push_a, pop_a, busy_a, done_a, error_a;
  logic [W-1:0] write_data_a;
  logic [7:0]   err_count_a;

  // Direct mode bypasses the FIFO model so flags can be forced to corner cases.
  logic direct  = 1'b0;
  logic d_full  = 1'b0;
  logic d_empty = 1'b1;
  int   fault_mode = 0;  // 0 ideal, 1 corrupt entry 02, 2 corrupt every entry

  logic [W-1:0] mem [D];
  int           rd_p = 0, wr_p = 0, cnt = 0;
  logic [W-1:0] f_head, f_data;
  logic         acc_pop, acc_push;

  int          total = 0, bad = 0;
  int          m_writes = 0, m_pops = 0, m_mism = 0;
  logic        m_err = 1'b0;
  logic        mon_en = 1'b0;
  logic [15:0] lfsr_m = SEED;

  fifo_traffic_generator #(
    .width(W), .depth(D), .allow_push_when_full_with_pop(1'b0),
    .random_cycles(RC), .lfsr_seed(SEED)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .empty(empty), .full(full),
    .read_data(read_data), .push(push), .pop(pop), .write_data(write_data),
    .busy(busy), .done(done), .error(error), .err_count(err_count)
  );

  fifo_traffic_generator #(
    .width(W), .depth(D), .allow_push_when_full_with_pop(1'b1),
    .random_cycles(RC), .lfsr_seed(SEED)
  ) u_allow (
    .clk(clk), .rst(rst), .start(start), .empty(empty), .full(full),
    .read_data(read_data), .push(push_a), .pop(pop_a), .write_data(write_data_a),
    .busy(busy_a), .done(done_a), .error(error_a), .err_count(err_count_a)
  );

  assign f_head = mem[rd_p];
  always_comb begin
    f_data = f_head;
    if (fault_mode == 1 && f_head == 8'h02) f_data = f_head ^ 8'h01;
    else if (fault_mode == 2)               f_data = f_head ^ 8'h80;
  end

  assign empty     = direct ? d_empty : (cnt == 0);
  assign full      = direct ? d_full  : (cnt == D);
  assign read_data = direct ? '0 : f_data;
  assign acc_pop   = (pop === 1'b1) && (cnt != 0);
  assign acc_push  = (push === 1'b1) && ((cnt != D) || acc_pop);

  always @(posedge clk) begin
    if (rst) begin
      rd_p <= 0;
      wr_p <= 0;
      cnt  <= 0;
    end else if (!direct) begin
      if (acc_push) begin
        mem[wr_p] <= write_data;
        wr_p      <= (wr_p + 1) % D;
      end
      if (acc_pop) rd_p <= (rd_p + 1) % D;
      cnt <= cnt + int'(acc_push) - int'(acc_pop);
    end
  end

  // Reference stream: n-th push carries n mod 256, n-th pop must return n mod 256.
  always @(posedge clk) begin
    if (rst) begin
      m_writes <= 0;
      m_pops   <= 0;
      m_mism   <= 0;
      m_err    <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (push === 1'b1) m_writes <= m_writes + 1;
      if (pop === 1'b1) begin
        m_pops <= m_pops + 1;
        if (read_data !== W'(m_pops)) begin
          m_err  <= 1'b1;
          m_mism <= m_mism + 1;
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (rst) begin
        total++;
        if (push !== 1'b0 || pop !== 1'b0) begin
          bad++;
          $display("FAIL mon_reset_strobe: push=%b pop=%b, expected 0 0", push, pop);
        end
      end else begin
        total++;
        if ((push === 1'b1 && full === 1'b1) || (pop === 1'b1 && empty === 1'b1)) begin
          bad++;
          $display("FAIL mon_protocol: push=%b pop=%b full=%b empty=%b", push, pop, full, empty);
        end
        total++;
        if ((push_a === 1'b1 && full === 1'b1 && pop_a !== 1'b1) || (pop_a === 1'b1 && empty === 1'b1)) begin
          bad++;
          $display("FAIL mon_protocol_allow: push=%b pop=%b full=%b empty=%b", push_a, pop_a, full, empty);
        end
        total++;
        if (write_data !== W'(m_writes)) begin
          bad++;
          $display("FAIL mon_write_data: got %h expected %h", write_data, W'(m_writes));
        end
        total++;
        if (error !== m_err) begin
          bad++;
          $display("FAIL mon_error: got %b expected %b", error, m_err);
        end
        total++;
        if (err_count !== 8'((m_mism > 255) ? 255 : m_mism)) begin
          bad++;
          $display("FAIL mon_err_count: got %0d expected %0d", err_count, (m_mism > 255) ? 255 : m_mism);
        end
      end
    end
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    lfsr_m = SEED;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: busy=%b done=%b error=%b, expected 0 0 0", busy, done, error);
    end
    total++;
    if (err_count !== 8'h00 || write_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_counters: err_count=%0d write_data=%h, expected 0 00", err_count, write_data);
    end
    total++;
    if (push !== 1'b0 || pop !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_strobes: push=%b pop=%b, expected 0 0", push, pop);
    end
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] pw[$];
    logic [W-1:0] pr[$];
    logic         exp_push, exp_pop;
    int           n, waited;
    do_reset();
    fault_mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (pr.size() < 4 && n < 40) begin
      if (push === 1'b1) pw.push_back(write_data);
      if (pop === 1'b1) begin
        total++;
        if (pw.size() != 4) begin
          bad++;
          $display("FAIL fill_before_drain: pushes=%0d at first pops, expected 4", pw.size());
        end
        pr.push_back(read_data);
      end
      if (pr.size() < 4) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= pw.size() || pw[i] !== W'(i)) begin
        bad++;
        $display("FAIL fill_data[%0d]: pushes seen=%0d, expected value %h", i, pw.size(), W'(i));
      end
      total++;
      if (i >= pr.size() || pr[i] !== W'(i)) begin
        bad++;
        $display("FAIL drain_data[%0d]: pops seen=%0d, expected value %h", i, pr.size(), W'(i));
      end
    end
    @(negedge clk);
    total++;
    if (push !== 1'b0 || pop !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL drain_empty_cycle: push=%b pop=%b busy=%b, expected 0 0 1", push, pop, busy);
    end
    for (int k = 0; k < RC; k++) begin
      @(negedge clk);
      start    = 1'b0;
      exp_pop  = lfsr_m[1] & ~empty;
      exp_push = lfsr_m[0] & ~full;
      total++;
      if (push !== exp_push || pop !== exp_pop) begin
        bad++;
        $display("FAIL random_strobe k=%0d: push=%b pop=%b, expected %b %b", k, push, pop, exp_push, exp_pop);
      end
      lfsr_m = lfsr_next(lfsr_m);
      if (k == 10) start = 1'b1;  // must be ignored while busy
    end
    waited = 0;
    while (done !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL flush_done: done=%b busy=%b empty=%b, expected 1 0 1", done, busy, empty);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL done_hold: done=%b, expected 1", done);
    end
  endtask

  task automatic test_bit_flip();
    logic found;
    do_reset();
    fault_mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pop === 1'b1 && f_head == 8'h02) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL flip_pop_seen: pop of entry 02 not observed within 40 cycles");
    end else begin
      total++;
      if (error !== 1'b0) begin
        bad++;
        $display("FAIL flip_error_early: error=%b on the pop cycle, expected 0", error);
      end
      @(negedge clk);
      total++;
      if (error !== 1'b1 || err_count !== 8'd1) begin
        bad++;
        $display("FAIL flip_error_pulse: error=%b err_count=%0d, expected 1 1", error, err_count);
      end
      @(negedge clk);
      total++;
      if (error !== 1'b0 || err_count !== 8'd1) begin
        bad++;
        $display("FAIL flip_error_single: error=%b err_count=%0d, expected 0 1", error, err_count);
      end
    end
    fault_mode = 0;
  endtask

  task automatic test_reset_mid_random();
    do_reset();
    fault_mode = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    total++;
    if (busy !== 1'b1 || err_count === 8'h00) begin
      bad++;
      $display("FAIL pre_reset_state: busy=%b err_count=%0d, expected 1 and nonzero", busy, err_count);
    end
    rst = 1'b1;
    #1;
    total++;
    if (push !== 1'b0 || pop !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobe_comb: push=%b pop=%b, expected 0 0", push, pop);
    end
    @(negedge clk);
    rst        = 1'b0;
    fault_mode = 0;
    lfsr_m     = SEED;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || err_count !== 8'h00 || write_data !== 8'h00) begin
      bad++;
      $display("FAIL post_reset: busy=%b done=%b error=%b err_count=%0d write_data=%h, expected 0 0 0 0 00",
               busy, done, error, err_count, write_data);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (push !== 1'b1 || write_data !== 8'h00) begin
      bad++;
      $display("FAIL restart_first_write: push=%b write_data=%h, expected 1 00", push, write_data);
    end
  endtask

  task automatic test_allow();
    logic exp_pop, exp_push0, exp_push1;
    direct  = 1'b1;
    d_full  = 1'b0;
    d_empty = 1'b1;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    d_full  = 1'b1;
    d_empty = 1'b0;
    #1;
    total++;
    if (push !== 1'b0 || pop !== 1'b0) begin
      bad++;
      $display("FAIL fill_when_full: push=%b pop=%b, expected 0 0", push, pop);
    end
    @(negedge clk);
    d_full  = 1'b0;
    d_empty = 1'b1;
    for (int k = 0; k < RC; k++) begin
      @(negedge clk);
      d_full  = (lfsr_m[1:0] == 2'b11) ? 1'b1 : 1'($urandom_range(0, 1));
      d_empty = d_full ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      exp_pop   = lfsr_m[1] & ~d_empty;
      exp_push0 = lfsr_m[0] & ~d_full;
      exp_push1 = lfsr_m[0] & (~d_full | exp_pop);
      total++;
      if (push !== exp_push0 || pop !== exp_pop) begin
        bad++;
        $display("FAIL allow0_strobe k=%0d full=%b empty=%b: push=%b pop=%b, expected %b %b",
                 k, d_full, d_empty, push, pop, exp_push0, exp_pop);
      end
      total++;
      if (push_a !== exp_push1 || pop_a !== exp_pop || busy_a !== 1'b1) begin
        bad++;
        $display("FAIL allow1_strobe k=%0d full=%b empty=%b: push=%b pop=%b busy=%b, expected %b %b 1",
                 k, d_full, d_empty, push_a, pop_a, busy_a, exp_push1, exp_pop);
      end
      lfsr_m = lfsr_next(lfsr_m);
    end
    direct  = 1'b0;
    d_full  = 1'b0;
    d_empty = 1'b1;
  endtask

  task automatic test_saturation();
    int waited;
    do_reset();
    fault_mode = 2;
    for (int s = 0; s < 20 && m_pops < 300; s++) begin
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      waited = 0;
      while (done !== 1'b1 && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      total++;
      if (done !== 1'b1) begin
        bad++;
        $display("FAIL sat_sequence_timeout: done=%b after %0d cycles, expected 1", done, waited);
      end
    end
    total++;
    if (m_pops < 300 || err_count !== 8'hFF) begin
      bad++;
      $display("FAIL saturation: pops=%0d err_count=%0d, expected >=300 and 255", m_pops, err_count);
    end
    fault_mode = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_fill_drain();
    test_bit_flip();
    test_reset_mid_random();
    test_allow();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
